// File: rtl/neighbor_streamer.sv
// -----------------------------------------------------------------------------
// neighbor_streamer
//
// Graph-memory front end for the best-first search engine. Takes a vertex id,
// walks that vertex's fixed-degree adjacency list in BRAM, fetches each
// neighbor's coordinate word and streams {id, coordinates} one neighbor at a
// time over a valid/ready interface. done_out pulses once at the end of every
// list, including empty lists.
//
// Ports
//   clk_in            clock
//   rst_in            asynchronous, active-low reset
//   req_valid_in      expand request
//   req_id_in         vertex to expand
//   req_ready_out     high only while idle
//   adj_addr_out      adjacency BRAM address (id*DEGREE + slot)
//   adj_data_in       neighbor id, 32'hFFFF_FFFF marks an empty slot
//   coord_addr_out    coordinate BRAM address (one wide word per vertex)
//   coord_data_in     packed coordinates, [31:0] is dimension 0
//   vertex_out        neighbor coordinates
//   vertex_id_out     neighbor id
//   vertex_valid_out  output beat valid
//   vertex_ready_in   downstream accept
//   done_out          one-cycle pulse when the list is finished
//   count_out         neighbors emitted for the current request (saturating)
//   skipped_out       out-of-range ids skipped for the current request
//
// Both BRAMs have a 2-cycle read latency: an address driven in cycle t is
// sampled at the edge that ends cycle t+2. Addresses are registered and held.
// -----------------------------------------------------------------------------
module neighbor_streamer #(
  parameter int DIM          = 2,
  parameter int DEGREE       = 8,
  parameter int NUM_VERTICES = 1024,
  parameter int ADDR_W       = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 req_valid_in,
  input  logic [31:0]          req_id_in,
  output logic                 req_ready_out,
  output logic [ADDR_W-1:0]    adj_addr_out,
  input  logic [31:0]          adj_data_in,
  output logic [ADDR_W-1:0]    coord_addr_out,
  input  logic [32*DIM-1:0]    coord_data_in,
  output logic [DIM-1:0][31:0] vertex_out,
  output logic [31:0]          vertex_id_out,
  output logic                 vertex_valid_out,
  input  logic                 vertex_ready_in,
  output logic                 done_out,
  output logic [15:0]          count_out,
  output logic [15:0]          skipped_out
);

  localparam int             J_W        = (DEGREE > 1) ? $clog2(DEGREE) : 1;
  localparam logic [31:0]    SENTINEL   = 32'hFFFF_FFFF;
  localparam logic [31:0]    NUM_V      = 32'(NUM_VERTICES);
  localparam logic [J_W-1:0] J_LAST     = J_W'(DEGREE - 1);
  // Wait-counter values at which the BRAM data is valid on the input pins.
  // ADJ_RD spans the two latency cycles plus the sampling cycle, so that
  // ADJ_CHK works on a registered id while the coordinate read is already
  // in flight.
  localparam logic [1:0]     ADJ_SAMPLE = 2'd2;
  localparam logic [1:0]     CRD_SAMPLE = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADJ_RD,
    S_ADJ_CHK,
    S_CRD_RD,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                state_reg,      state_next;
  logic [31:0]           req_id_reg,     req_id_next;
  logic [J_W-1:0]        j_reg,          j_next;
  logic [1:0]            wait_reg,       wait_next;
  logic [31:0]           nid_reg,        nid_next;
  logic [ADDR_W-1:0]     adj_addr_reg,   adj_addr_next;
  logic [ADDR_W-1:0]     coord_addr_reg, coord_addr_next;
  logic [DIM-1:0][31:0]  vertex_reg,     vertex_next;
  logic [31:0]           vertex_id_reg,  vertex_id_next;
  logic [15:0]           count_reg,      count_next;
  logic [15:0]           skipped_reg,    skipped_next;
  logic                  advance;

  logic [DIM-1:0][31:0]  coord_words;

  // Unpack the flat coordinate word, dimension 0 in the low bits.
  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_unpack
      assign coord_words[gi] = coord_data_in[32*gi +: 32];
    end
  endgenerate

  function automatic logic [ADDR_W-1:0] adj_addr_of(input logic [31:0]    id,
                                                    input logic [J_W-1:0] j);
    return ADDR_W'(id * 32'(DEGREE) + 32'(j));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg      <= S_IDLE;
      req_id_reg     <= '0;
      j_reg          <= '0;
      wait_reg       <= '0;
      nid_reg        <= '0;
      adj_addr_reg   <= '0;
      coord_addr_reg <= '0;
      vertex_reg     <= '0;
      vertex_id_reg  <= '0;
      count_reg      <= '0;
      skipped_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      req_id_reg     <= req_id_next;
      j_reg          <= j_next;
      wait_reg       <= wait_next;
      nid_reg        <= nid_next;
      adj_addr_reg   <= adj_addr_next;
      coord_addr_reg <= coord_addr_next;
      vertex_reg     <= vertex_next;
      vertex_id_reg  <= vertex_id_next;
      count_reg      <= count_next;
      skipped_reg    <= skipped_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    req_id_next     = req_id_reg;
    j_next          = j_reg;
    wait_next       = wait_reg;
    nid_next        = nid_reg;
    adj_addr_next   = adj_addr_reg;
    coord_addr_next = coord_addr_reg;
    vertex_next     = vertex_reg;
    vertex_id_next  = vertex_id_reg;
    count_next      = count_reg;
    skipped_next    = skipped_reg;
    advance         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // req_ready_out is high exactly in this state
        if (req_valid_in) begin
          req_id_next   = req_id_in;
          j_next        = '0;
          wait_next     = '0;
          count_next    = '0;
          skipped_next  = '0;
          adj_addr_next = adj_addr_of(req_id_in, '0);
          state_next    = S_ADJ_RD;
        end
      end

      S_ADJ_RD: begin
        if (wait_reg == ADJ_SAMPLE) begin
          nid_next = adj_data_in;
          // Start the coordinate read right away for an in-range id; sentinel
          // and out-of-range slots leave the coordinate address untouched.
          if (adj_data_in < NUM_V) begin
            coord_addr_next = ADDR_W'(adj_data_in);
          end
          state_next = S_ADJ_CHK;
        end else begin
          wait_next = wait_reg + 2'd1;
        end
      end

      S_ADJ_CHK: begin
        wait_next = '0;
        if (nid_reg == SENTINEL) begin
          state_next = S_DONE;
        end else if (nid_reg >= NUM_V) begin
          skipped_next = sat_inc(skipped_reg);
          advance      = 1'b1;
        end else begin
          state_next = S_CRD_RD;
        end
      end

      S_CRD_RD: begin
        if (wait_reg == CRD_SAMPLE) begin
          vertex_next    = coord_words;
          vertex_id_next = nid_reg;
          state_next     = S_EMIT;
        end else begin
          wait_next = wait_reg + 2'd1;
        end
      end

      S_EMIT: begin
        // payload registers are only written in CRD_RD, so they hold here
        if (vertex_ready_in) begin
          count_next = sat_inc(count_reg);
          advance    = 1'b1;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Move to the next slot or finish the list.
    if (advance) begin
      wait_next = '0;
      if (j_reg == J_LAST) begin
        state_next = S_DONE;
      end else begin
        j_next        = j_reg + J_W'(1);
        adj_addr_next = adj_addr_of(req_id_reg, j_reg + J_W'(1));
        state_next    = S_ADJ_RD;
      end
    end
  end

  assign req_ready_out    = (state_reg == S_IDLE);
  assign vertex_valid_out = (state_reg == S_EMIT);
  assign done_out         = (state_reg == S_DONE);
  assign adj_addr_out     = adj_addr_reg;
  assign coord_addr_out   = coord_addr_reg;
  assign vertex_out       = vertex_reg;
  assign vertex_id_out    = vertex_id_reg;
  assign count_out        = count_reg;
  assign skipped_out      = skipped_reg;

endmodule

// File: tb/tb_neighbor_streamer.sv
// -----------------------------------------------------------------------------
// tb_neighbor_streamer
//
// Directed bench for neighbor_streamer (DIM=2, DEGREE=8, NUM_VERTICES=1024).
// Both BRAMs are modelled with a 2-cycle registered read. Coordinates of
// vertex n are (n, 2n). Cycle offsets are relative to the accepting edge k:
// the cycle right after edge k is k+1.
//
// Adjacency contents (all other slots hold the sentinel):
//   vertex 0 : sentinel in slot 0
//   vertex 1 : 5, 6, 7, sentinel
//   vertex 2 : 4, 2000, 9, sentinel
//   vertex 3 : 10 .. 17
// -----------------------------------------------------------------------------
module tb_neighbor_streamer;

  localparam int          DIM          = 2;
  localparam int          DEGREE       = 8;
  localparam int          NUM_VERTICES = 1024;
  localparam int          ADDR_W       = 16;
  localparam logic [31:0] SENT         = 32'hFFFF_FFFF;

  logic                 clk_in          = 1'b0;
  logic                 rst_in          = 1'b1;
  logic                 req_valid_in    = 1'b0;
  logic [31:0]          req_id_in       = '0;
  logic                 req_ready_out;
  logic [ADDR_W-1:0]    adj_addr_out;
  logic [31:0]          adj_data_in     = '0;
  logic [ADDR_W-1:0]    coord_addr_out;
  logic [32*DIM-1:0]    coord_data_in   = '0;
  logic [DIM-1:0][31:0] vertex_out;
  logic [31:0]          vertex_id_out;
  logic                 vertex_valid_out;
  logic                 vertex_ready_in = 1'b1;
  logic                 done_out;
  logic [15:0]          count_out;
  logic [15:0]          skipped_out;

  always #5 clk_in = ~clk_in;

  neighbor_streamer #(
    .DIM          (DIM),
    .DEGREE       (DEGREE),
    .NUM_VERTICES (NUM_VERTICES),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .req_valid_in     (req_valid_in),
    .req_id_in        (req_id_in),
    .req_ready_out    (req_ready_out),
    .adj_addr_out     (adj_addr_out),
    .adj_data_in      (adj_data_in),
    .coord_addr_out   (coord_addr_out),
    .coord_data_in    (coord_data_in),
    .vertex_out       (vertex_out),
    .vertex_id_out    (vertex_id_out),
    .vertex_valid_out (vertex_valid_out),
    .vertex_ready_in  (vertex_ready_in),
    .done_out         (done_out),
    .count_out        (count_out),
    .skipped_out      (skipped_out)
  );

  // ---------------- BRAM models, 2-cycle read latency ----------------
  logic [31:0]       adj_mem [0:65535];
  logic [ADDR_W-1:0] adj_p1 = '0;
  logic [ADDR_W-1:0] crd_p1 = '0;

  always @(posedge clk_in) begin
    adj_p1        <= adj_addr_out;
    adj_data_in   <= adj_mem[adj_p1];
    crd_p1        <= coord_addr_out;
    coord_data_in <= {{15'd0, crd_p1, 1'b0}, {16'd0, crd_p1}};
  end

  // ---------------- bookkeeping ----------------
  int          vectors     = 0;
  int          miscompares = 0;
  int          nbeats;
  int          done_rel;
  int          first_valid_rel;
  int          busy_ready_hits;
  logic [31:0] beat_id  [0:15];
  logic [63:0] beat_v   [0:15];
  int          beat_rel [0:15];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_req_ready"},  64'(req_ready_out),    64'd1);
    check({pfx, "_valid"},      64'(vertex_valid_out), 64'd0);
    check({pfx, "_done"},       64'(done_out),         64'd0);
    check({pfx, "_adj_addr"},   64'(adj_addr_out),     64'd0);
    check({pfx, "_coord_addr"}, 64'(coord_addr_out),   64'd0);
    check({pfx, "_vertex"},     64'(vertex_out),       64'd0);
    check({pfx, "_vertex_id"},  64'(vertex_id_out),    64'd0);
    check({pfx, "_count"},      64'(count_out),        64'd0);
    check({pfx, "_skipped"},    64'(skipped_out),      64'd0);
  endtask

  // Three cycles after the done cycle: done stays low, the block is idle
  // and the count is held.
  task automatic after_done(input string pfx, input int exp_count);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check($sformatf("%s_post%0d_done", pfx, i),  64'(done_out),      64'd0);
      check($sformatf("%s_post%0d_ready", pfx, i), 64'(req_ready_out), 64'd1);
      check($sformatf("%s_post%0d_count", pfx, i), 64'(count_out),     64'(exp_count));
    end
  endtask

  // Issue one request and collect beats until done_out (bounded).
  // stall_beat/stall_len: hold ready low for stall_len cycles on that beat.
  // busy_at: if > 0, pulse a second request in cycle k+busy_at.
  task automatic run_request(input logic [31:0] id, input int stall_beat,
                             input int stall_len, input int busy_at);
    int          rel;
    int          stall_left;
    bit          in_stall;
    logic [31:0] hold_id;
    logic [63:0] hold_v;
    nbeats          = 0;
    done_rel        = -1;
    first_valid_rel = -1;
    busy_ready_hits = 0;
    stall_left      = stall_len;
    in_stall        = 1'b0;
    hold_id         = '0;
    hold_v          = '0;
    @(negedge clk_in);
    check($sformatf("req%0d_ready_before", id), 64'(req_ready_out), 64'd1);
    $display("request: id=%0d", id);
    req_id_in       = id;
    req_valid_in    = 1'b1;
    vertex_ready_in = 1'b1;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    rel = 1;
    for (int n = 0; n < 400; n++) begin
      if (busy_at > 0) begin
        req_valid_in = (rel == busy_at);
        if (rel == busy_at) req_id_in = 32'd3;
      end
      if (req_ready_out) busy_ready_hits++;
      if (in_stall) begin
        check($sformatf("req%0d_stall_valid_k%0d", id, rel), 64'(vertex_valid_out), 64'd1);
        check($sformatf("req%0d_stall_id_k%0d", id, rel),    64'(vertex_id_out),    64'(hold_id));
        check($sformatf("req%0d_stall_crd_k%0d", id, rel),   64'(vertex_out),       hold_v);
      end
      if (vertex_valid_out) begin
        if (first_valid_rel < 0) first_valid_rel = rel;
        if (nbeats == stall_beat && stall_left > 0) begin
          if (!in_stall) begin
            hold_id = vertex_id_out;
            hold_v  = 64'(vertex_out);
          end
          in_stall        = 1'b1;
          stall_left--;
          vertex_ready_in = 1'b0;
        end else begin
          in_stall        = 1'b0;
          vertex_ready_in = 1'b1;
          if (nbeats < 16) begin
            beat_id[nbeats]  = vertex_id_out;
            beat_v[nbeats]   = 64'(vertex_out);
            beat_rel[nbeats] = rel;
          end
          $display("beat %0d: id=%0d c0=%0d c1=%0d at k+%0d",
                   nbeats, vertex_id_out, vertex_out[0], vertex_out[1], rel);
          nbeats++;
        end
      end else begin
        in_stall        = 1'b0;
        vertex_ready_in = 1'b1;
      end
      if (done_out) begin
        done_rel = rel;
        break;
      end
      @(negedge clk_in);
      rel++;
    end
    req_valid_in    = 1'b0;
    vertex_ready_in = 1'b1;
    $display("done: id=%0d beats=%0d done at k+%0d count=%0d skipped=%0d",
             id, nbeats, done_rel, count_out, skipped_out);
  endtask

  function automatic logic [63:0] crd(input int n);
    return {32'(2 * n), 32'(n)};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    for (int a = 0; a < 65536; a++) adj_mem[a] = SENT;
    for (int i = 0; i < 8; i++) adj_mem[24 + i] = 32'(10 + i);
    adj_mem[8]  = 32'd5;
    adj_mem[9]  = 32'd6;
    adj_mem[10] = 32'd7;
    adj_mem[16] = 32'd4;
    adj_mem[17] = 32'd2000;
    adj_mem[18] = 32'd9;

    // power-on reset
    #1 rst_in = 1'b0;
    #1 check_reset("por");
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;

    // full list: vertex 3 -> 10..17
    run_request(32'd3, -1, 0, 0);
    check("full_beats",       64'(nbeats),          64'd8);
    check("full_first_valid", 64'(first_valid_rel), 64'd7);
    check("full_done_cycle",  64'(done_rel),        64'd57);
    check("full_count",       64'(count_out),       64'd8);
    check("full_skipped",     64'(skipped_out),     64'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_id%0d", i),  64'(beat_id[i]),  64'(10 + i));
      check($sformatf("full_crd%0d", i), beat_v[i],        crd(10 + i));
      check($sformatf("full_rel%0d", i), 64'(beat_rel[i]), 64'(7 + 7 * i));
    end
    after_done("full", 8);

    // sentinel at slot 3: vertex 1 -> 5, 6, 7
    run_request(32'd1, -1, 0, 0);
    check("sent_beats",      64'(nbeats),         64'd3);
    check("sent_done_cycle", 64'(done_rel),       64'd26);
    check("sent_count",      64'(count_out),      64'd3);
    check("sent_coord_addr", 64'(coord_addr_out), 64'd7);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sent_id%0d", i),  64'(beat_id[i]), 64'(5 + i));
      check($sformatf("sent_crd%0d", i), beat_v[i],       crd(5 + i));
    end
    after_done("sent", 3);

    // backpressure: ready low for 10 cycles on the second beat
    run_request(32'd3, 1, 10, 0);
    check("bp_beats",      64'(nbeats),      64'd8);
    check("bp_done_cycle", 64'(done_rel),    64'd67);
    check("bp_count",      64'(count_out),   64'd8);
    check("bp_id1",        64'(beat_id[1]),  64'd11);
    check("bp_crd1",       beat_v[1],        crd(11));
    check("bp_rel1",       64'(beat_rel[1]), 64'd24);
    check("bp_id2",        64'(beat_id[2]),  64'd12);
    check("bp_rel2",       64'(beat_rel[2]), 64'd31);
    check("bp_id7",        64'(beat_id[7]),  64'd17);
    after_done("bp", 8);

    // out-of-range neighbor: vertex 2 -> 4, 2000, 9, sentinel
    run_request(32'd2, -1, 0, 0);
    check("oor_beats",      64'(nbeats),      64'd2);
    check("oor_done_cycle", 64'(done_rel),    64'd23);
    check("oor_count",      64'(count_out),   64'd2);
    check("oor_skipped",    64'(skipped_out), 64'd1);
    check("oor_id0",        64'(beat_id[0]),  64'd4);
    check("oor_crd0",       beat_v[0],        crd(4));
    check("oor_id1",        64'(beat_id[1]),  64'd9);
    check("oor_crd1",       beat_v[1],        crd(9));
    check("oor_rel1",       64'(beat_rel[1]), 64'd18);
    after_done("oor", 2);

    // empty list with a request pulsed while busy
    run_request(32'd0, -1, 0, 2);
    check("empty_beats",      64'(nbeats),          64'd0);
    check("empty_done_cycle", 64'(done_rel),        64'd5);
    check("empty_count",      64'(count_out),       64'd0);
    check("empty_busy_ready", 64'(busy_ready_hits), 64'd0);
    after_done("empty", 0);

    // reset while a beat is being offered
    @(negedge clk_in);
    $display("request: id=3 (reset while valid)");
    req_id_in       = 32'd3;
    req_valid_in    = 1'b1;
    vertex_ready_in = 1'b0;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (vertex_valid_out) break;
      @(negedge clk_in);
    end
    check("rst_pre_valid", 64'(vertex_valid_out), 64'd1);
    check("rst_pre_id",    64'(vertex_id_out),    64'd10);
    #2 rst_in = 1'b0;
    #1 check_reset("mid");
    @(negedge clk_in);
    check("mid_done_held", 64'(done_out), 64'd0);
    rst_in          = 1'b1;
    vertex_ready_in = 1'b1;

    run_request(32'd2, -1, 0, 0);
    check("post_rst_beats",      64'(nbeats),      64'd2);
    check("post_rst_done_cycle", 64'(done_rel),    64'd23);
    check("post_rst_count",      64'(count_out),   64'd2);
    check("post_rst_skipped",    64'(skipped_out), 64'd1);
    check("post_rst_id1",        64'(beat_id[1]),  64'd9);
    after_done("post_rst", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/neighbor_streamer.md
# neighbor_streamer

Graph-memory front end for the best-first search engine. Accepts a vertex id, walks that vertex's fixed-degree adjacency list in BRAM, fetches each neighbor's coordinates, and streams `{id, coordinates}` one neighbor at a time over a valid/ready interface. Its output drives the search engine's vertex input. `done_out` marks the end of each list.

## Interface
- `DIM`, 2: coordinate dimensions, 32 bits each.
- `DEGREE`, 8: adjacency slots per vertex, power of two, 1..256.
- `NUM_VERTICES`, 1024: valid id range is `0..NUM_VERTICES-1`.
- `ADDR_W`, 16: BRAM address width.

- `clk_in` in 1: clock.
- `rst_in` in 1: asynchronous, active-low reset.
- `req_valid_in` in 1: expand request.
- `req_id_in` in 32: vertex to expand.
- `req_ready_out` out 1: high only in IDLE.
- `adj_addr_out` out ADDR_W: adjacency BRAM address.
- `adj_data_in` in 32: neighbor id, or `32'hFFFF_FFFF` for an empty slot.
- `coord_addr_out` out ADDR_W: coordinate BRAM address, one wide word per vertex.
- `coord_data_in` in 32×DIM: packed coordinates; `[31:0]` is dimension 0.
- `vertex_out` out 32 [DIM-1:0]: neighbor coordinates.
- `vertex_id_out` out 32: neighbor id.
- `vertex_valid_out` out 1: output beat valid.
- `vertex_ready_in` in 1: downstream accept.
- `done_out` out 1: one-cycle pulse when the list is finished.
- `count_out` out 16: neighbors emitted for the current request; held until the next request.
- `skipped_out` out 16: out-of-range ids skipped for the current request.

## Operation
- BRAM read latency is 2 cycles: an address driven in cycle t is sampled at the edge ending cycle t+2. Addresses are registered and held through the wait.
- Adjacency address = `id*DEGREE + j`, truncated to ADDR_W. Coordinate address = `nid`, truncated to ADDR_W.
- States: IDLE, ADJ_RD, ADJ_CHK, CRD_RD, EMIT, DONE.
- **IDLE:** on `req_valid_in && req_ready_out`, latch the id, clear `j`, `count_out` and `skipped_out`, then go to ADJ_RD.
- **ADJ_RD:** drive the adjacency address and wait 2 cycles.
- **ADJ_CHK:** evaluated on the sampled data.
  - Sentinel: go to DONE.
  - `nid >= NUM_VERTICES`: increment `skipped_out`, then advance.
  - Otherwise latch `nid` and go to CRD_RD.
- **CRD_RD:** drive `coord_addr_out`, wait 2 cycles, latch the coordinates, go to EMIT.
- **EMIT:** `vertex_valid_out` is high and `vertex_out` / `vertex_id_out` are stable until `vertex_ready_in`. On the handshake edge, increment `count_out`, then advance.
- **Advance:** if `j == DEGREE-1`, go to DONE; else `j++` and go to ADJ_RD.
- **DONE:** `done_out` is high for one cycle, then IDLE.
- Each list produces exactly one `done_out`, including empty lists.
- Counters saturate at `16'hFFFF`.

## Timing
- Reset (asynchronous assert, release synchronous to `clk_in`) values:
  - state IDLE;
  - `req_ready_out` = 1;
  - `vertex_valid_out`, `done_out` = 0;
  - all address and data outputs and counters = 0.
- Reset asserted mid-list aborts immediately. No `done_out` is produced for the aborted request.
- Request accepted at edge k:
  - `adj_addr_out` is valid in cycle k+1;
  - the first `coord_addr_out` is in cycle k+4;
  - the first `vertex_valid_out` is in cycle k+7 when it is not stalled.
- After an EMIT handshake at edge e, the next adjacency address appears in cycle e+1. With `vertex_ready_in` held high, each neighbor takes 7 cycles.
- A sentinel in slot 0 gives `done_out` at cycle k+5.
- With `DEGREE` valid neighbors and no stall, `done_out` is at cycle k+7·DEGREE+1.
- `req_ready_out` is 0 from edge k until the cycle after `done_out`. A request presented while busy is ignored and is not queued.
- Once `vertex_valid_out` rises it never drops without a handshake, and its payload does not change while it is high.

## Test plan
- **Full list:** DEGREE=8, vertex 3 has neighbors 10..17, coordinates (n, 2n), ready held high.
  - Required: 8 beats in order, ids 10..17, coordinates (10,20)..(17,34).
  - Required: first valid at k+7, `done_out` at k+57, `count_out` = 8.
- **Sentinel at slot 3:** neighbors 5, 6, 7, then `FFFF_FFFF`.
  - Required: 3 beats, one `done_out`, `count_out` = 3, no coordinate read after the sentinel.
- **Backpressure:** ready held low for 10 cycles on beat 2.
  - Required: valid stays high, id and coordinates are unchanged, no extra beat, total latency grows by exactly 10.
- **Out-of-range id:** NUM_VERTICES=1024, neighbors {4, 2000, 9, sentinel}.
  - Required: beats 4 and 9 only, `skipped_out` = 1, `count_out` = 2.
- **Empty list plus busy request:** vertex 0 has a sentinel in slot 0.
  - Required: `done_out` at k+5 with zero beats.
  - Required: a second `req_valid_in` pulsed at k+2 is ignored.
- **Reset mid-EMIT:** pull `rst_in` low while valid is high.
  - Required: all outputs return to their reset values asynchronously.
  - Required: a new request after release completes normally.
